// File: rtl/softmax_job_sched_pkg.sv
// Shared types and default sizing for the softmax job scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package softmax_job_sched_pkg;

  localparam int SM_ADDRSIZE  = 9;
  localparam int SM_DATAWIDTH = 32;
  localparam int SM_QDEPTH    = 4;
  localparam int SM_TIMEOUT   = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_INIT,
    S_START,
    S_RUN,
    S_CMPL
  } state_t;

endpackage

// File: rtl/softmax_job_sched_if.sv
// Job request, engine control, result write and completion bundle.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake; engine beats cannot be stalled.
interface softmax_job_sched_if
  import softmax_job_sched_pkg::*;
#(
  parameter int ADDRSIZE  = SM_ADDRSIZE,
  parameter int DATAWIDTH = SM_DATAWIDTH
) ();

  logic                   req_valid;
  logic                   req_ready;
  logic [ADDRSIZE-1:0]    req_start_addr;
  logic [ADDRSIZE-1:0]    req_end_addr;
  logic [ADDRSIZE-1:0]    req_out_base;
  logic [1:0]             req_id;
  logic                   sm_rst;
  logic                   sm_init;
  logic                   sm_start;
  logic [ADDRSIZE-1:0]    sm_start_addr;
  logic [ADDRSIZE-1:0]    sm_end_addr;
  logic                   sm_done;
  logic [DATAWIDTH-1:0]   sm_outp0;
  logic [DATAWIDTH-1:0]   sm_outp1;
  logic                   wr_en;
  logic [ADDRSIZE-1:0]    wr_addr;
  logic [2*DATAWIDTH-1:0] wr_data;
  logic                   cmp_valid;
  logic [1:0]             cmp_id;
  logic                   cmp_err;
  logic                   busy;

  // Scheduler side
  modport slave (
    input  req_valid, req_start_addr, req_end_addr, req_out_base, req_id,
           sm_done, sm_outp0, sm_outp1,
    output req_ready, sm_rst, sm_init, sm_start, sm_start_addr, sm_end_addr,
           wr_en, wr_addr, wr_data, cmp_valid, cmp_id, cmp_err, busy
  );

  // Host / engine side
  modport master (
    output req_valid, req_start_addr, req_end_addr, req_out_base, req_id,
           sm_done, sm_outp0, sm_outp1,
    input  req_ready, sm_rst, sm_init, sm_start, sm_start_addr, sm_end_addr,
           wr_en, wr_addr, wr_data, cmp_valid, cmp_id, cmp_err, busy
  );

endinterface

// File: rtl/sm_job_fifo.sv
// Small synchronous FIFO holding queued job descriptors.
// Latency: 1 cycle push-to-visible; head is read combinationally.
// Backpressure: o_full blocks pushes; pops on empty are ignored.
module sm_job_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr, w_rd;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_wr      = i_push & ~o_full;
  assign w_rd      = i_pop & ~o_empty;
  assign o_pop_dat = r_mem[r_rptr];

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_push_dat;
  end

  // Pointers and occupancy; simultaneous push and pop both take effect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
    end
  end

endmodule

// File: rtl/softmax_job_sched.sv
// Queues softmax jobs and sequences the engine: clear, init, start, collect N beats, complete.
// Latency: pop-to-sm_rst 1 cycle; beats written combinationally; completion 1 cycle after last beat.
// Backpressure: req_ready drops when the job queue is full; engine beats are never stalled.
module softmax_job_sched
  import softmax_job_sched_pkg::*;
#(
  parameter int ADDRSIZE  = SM_ADDRSIZE,
  parameter int DATAWIDTH = SM_DATAWIDTH,
  parameter int QDEPTH    = SM_QDEPTH,
  parameter int TIMEOUT   = SM_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  softmax_job_sched_if.slave bus
);

  localparam int JW = 3*ADDRSIZE + 2;
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t              r_state, w_next;
  logic [ADDRSIZE-1:0] r_start, r_end, r_base, r_cnt;
  logic [1:0]          r_id;
  logic                r_err;
  logic [WW-1:0]       r_wdog;
  logic                r_sm_rst, r_sm_init, r_sm_start, r_cmp_valid;

  logic                w_full, w_empty, w_push, w_pop, w_ready, w_act;
  logic [JW-1:0]       w_push_dat, w_head;
  logic [ADDRSIZE-1:0] w_h_start, w_h_end, w_h_base, w_n, w_cnt_nxt;
  logic [1:0]          w_h_id;
  logic                w_h_bad, w_beat, w_last, w_tmo;

  assign w_act      = ~reset;
  assign w_ready    = ~w_full & w_act;
  assign w_push     = bus.req_valid & w_ready;
  assign w_push_dat = {bus.req_start_addr, bus.req_end_addr, bus.req_out_base, bus.req_id};
  assign {w_h_start, w_h_end, w_h_base, w_h_id} = w_head;
  // Empty or inverted ranges never touch the engine
  assign w_h_bad    = (w_h_end <= w_h_start);

  sm_job_fifo #(.WIDTH(JW), .DEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign w_n       = r_end - r_start;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_beat    = w_act & (r_state == S_RUN) & bus.sm_done & (r_cnt < w_n);
  assign w_last    = w_beat & (w_cnt_nxt == w_n);
  assign w_tmo     = (r_state == S_RUN) & ~w_beat & (r_wdog == WW'(TIMEOUT - 1));

  // Next-state decode; a pop happens whenever IDLE or CMPL sees a queued job
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE, S_CMPL: begin
        if (r_state == S_CMPL) w_next = S_IDLE;
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = w_h_bad ? S_CMPL : S_CLR;
        end
      end
      S_CLR:   w_next = S_INIT;
      S_INIT:  w_next = S_START;
      S_START: w_next = S_RUN;
      S_RUN:   if (w_last || w_tmo) w_next = S_CMPL;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and control pulses, registered so each tracks its state exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sm_rst    <= 1'b0;
      r_sm_init   <= 1'b0;
      r_sm_start  <= 1'b0;
      r_cmp_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_sm_rst    <= (w_next == S_CLR);
      r_sm_init   <= (w_next == S_INIT);
      r_sm_start  <= (w_next == S_START);
      r_cmp_valid <= (w_next == S_CMPL);
    end
  end

  // Job registers load on pop and hold until the next pop; error latches on bad range or timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start <= '0;
      r_end   <= '0;
      r_base  <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
    end else if (w_pop) begin
      r_start <= w_h_start;
      r_end   <= w_h_end;
      r_base  <= w_h_base;
      r_id    <= w_h_id;
      r_err   <= w_h_bad;
    end else if (w_tmo) begin
      r_err   <= 1'b1;
    end
  end

  // Beat counter and RUN watchdog; the watchdog restarts on every accepted beat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_wdog <= '0;
    end else begin
      if (w_pop)       r_cnt <= '0;
      else if (w_beat) r_cnt <= w_cnt_nxt;
      if (r_state != S_RUN || w_beat) r_wdog <= '0;
      else                            r_wdog <= r_wdog + 1'b1;
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.sm_rst        = r_sm_rst | reset;
  assign bus.sm_init       = r_sm_init & w_act;
  assign bus.sm_start      = r_sm_start & w_act;
  assign bus.sm_start_addr = w_act ? r_start : '0;
  assign bus.sm_end_addr   = w_act ? r_end : '0;
  assign bus.wr_en         = w_beat;
  assign bus.wr_addr       = w_beat ? (r_base + r_cnt) : '0;
  assign bus.wr_data       = w_beat ? {bus.sm_outp1, bus.sm_outp0} : '0;
  assign bus.cmp_valid     = r_cmp_valid & w_act;
  assign bus.cmp_id        = (r_cmp_valid & w_act) ? r_id : 2'b00;
  assign bus.cmp_err       = r_cmp_valid & w_act & r_err;
  assign bus.busy          = w_act & ((r_state != S_IDLE) | ~w_empty);

endmodule

// File: tb/tb_softmax_job_sched.sv
// Directed bench for softmax_job_sched: cycle tables plus corner-case sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_softmax_job_sched;

  localparam int AS = 9;
  localparam int DW = 32;
  localparam int QD = 4;
  localparam int TO = 32;

  typedef struct packed {
    logic        rdy, rst, ini, sta, wr;
    logic [8:0]  wa;
    logic [63:0] wd;
    logic        cv;
    logic [1:0]  cid;
    logic        cer, bsy;
    logic [8:0]  sa, ea;
  } out_t;

  typedef struct {
    int          rv, s, e, b, id, dn;
    logic [31:0] d0, d1;
    out_t        x;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  softmax_job_sched_if #(.ADDRSIZE(AS), .DATAWIDTH(DW)) bus ();

  softmax_job_sched #(.ADDRSIZE(AS), .DATAWIDTH(DW), .QDEPTH(QD), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int rv, input int s, input int e, input int b, input int id,
                       input int dn, input logic [31:0] d0, input logic [31:0] d1);
    bus.req_valid      = rv[0];
    bus.req_start_addr = s[AS-1:0];
    bus.req_end_addr   = e[AS-1:0];
    bus.req_out_base   = b[AS-1:0];
    bus.req_id         = id[1:0];
    bus.sm_done        = dn[0];
    bus.sm_outp0       = d0;
    bus.sm_outp1       = d1;
  endtask

  function automatic out_t sample();
    out_t o;
    o.rdy = bus.req_ready;     o.rst = bus.sm_rst;    o.ini = bus.sm_init;
    o.sta = bus.sm_start;      o.wr  = bus.wr_en;     o.wa  = bus.wr_addr;
    o.wd  = bus.wr_data;       o.cv  = bus.cmp_valid; o.cid = bus.cmp_id;
    o.cer = bus.cmp_err;       o.bsy = bus.busy;
    o.sa  = bus.sm_start_addr; o.ea  = bus.sm_end_addr;
    return o;
  endfunction

  function automatic vec_t mk(input int rv, input int s, input int e, input int b, input int id,
                              input int dn, input logic [31:0] d0, input logic [31:0] d1,
                              input int rdy, input int rst, input int ini, input int sta,
                              input int wr, input int wa, input int cv, input int cid,
                              input int cer, input int bsy, input int sa, input int ea);
    vec_t v;
    v.rv = rv; v.s = s; v.e = e; v.b = b; v.id = id; v.dn = dn; v.d0 = d0; v.d1 = d1;
    v.x.rdy = rdy[0]; v.x.rst = rst[0]; v.x.ini = ini[0]; v.x.sta = sta[0];
    v.x.wr  = wr[0];  v.x.wa  = wa[8:0];
    v.x.wd  = wr[0] ? {d1, d0} : 64'd0;
    v.x.cv  = cv[0];  v.x.cid = cid[1:0]; v.x.cer = cer[0]; v.x.bsy = bsy[0];
    v.x.sa  = sa[8:0]; v.x.ea = ea[8:0];
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    out_t z;
    int   found, acc, tcmp, pulses, wrs, tc, cvs, rsts, bzs;
    int   ids[$];
    logic rdy4, cerr_b, rst_after, ce, errall;
    logic [1:0] cid_b, ci;

    // Reset with noisy inputs: only sm_rst may be high
    drive(1, 1, 3, 5, 1, 1, 32'hdead, 32'hbeef);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    z = '0; z.rst = 1'b1;
    chk_out("reset_outputs", sample(), z);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //          rv s e b   id dn d0            d1             rdy rst ini sta wr wa  cv cid cer bsy sa ea
    // Single job 0..4 -> base 16, id 1, one idle cycle between beats, stray beat in CMPL
    tbl.push_back(mk(1, 0, 4, 16, 1, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 0, 0,   0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'h11111111, 32'haaaa0000, 1, 0, 0, 0, 1, 16,  0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'h22222222, 32'hbbbb0001, 1, 0, 0, 0, 1, 17,  0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'h33333333, 32'hcccc0002, 1, 0, 0, 0, 1, 18,  0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'h44444444, 32'hdddd0003, 1, 0, 0, 0, 1, 19,  0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'h55555555, 32'heeee0004, 1, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 4));
    // Wrap: 2..5 -> base 510, id 2; writes 510, 511, 0; fourth beat ignored
    tbl.push_back(mk(1, 2, 5, 510, 2, 0, 32'h0,       32'h0,        1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 0, 0,   0, 0, 0, 1, 2, 5));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        1, 0, 1, 0, 0, 0,   0, 0, 0, 1, 2, 5));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h0,        32'h0,        1, 0, 0, 1, 0, 0,   0, 0, 0, 1, 2, 5));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'hcafe0000, 32'h00000001, 1, 0, 0, 0, 1, 510, 0, 0, 0, 1, 2, 5));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'hcafe0001, 32'h00000002, 1, 0, 0, 0, 1, 511, 0, 0, 0, 1, 2, 5));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'hcafe0002, 32'h00000003, 1, 0, 0, 0, 1, 0,   0, 0, 0, 1, 2, 5));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'hcafe0003, 32'h00000004, 1, 0, 0, 0, 0, 0,   1, 2, 0, 1, 2, 5));
    tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'hcafe0004, 32'h00000005, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2, 5));

    foreach (tbl[i]) begin
      tick();
      drive(tbl[i].rv, tbl[i].s, tbl[i].e, tbl[i].b, tbl[i].id, tbl[i].dn, tbl[i].d0, tbl[i].d1);
      #1;
      chk_out($sformatf("vec%0d", i), sample(), tbl[i].x);
    end

    // Bad jobs (equal and inverted range): straight to CMPL with error, engine untouched
    for (int j = 0; j < 2; j++) begin
      pulses = 0; wrs = 0; tc = -1; ce = 1'b0; ci = 2'b00;
      tick();
      drive(1, (j == 0) ? 8 : 9, (j == 0) ? 8 : 3, 0, (j == 0) ? 2 : 1, 0, 0, 0);
      for (int c = 1; c <= 6; c++) begin
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        pulses += int'(bus.sm_rst) + int'(bus.sm_init) + int'(bus.sm_start);
        wrs += int'(bus.wr_en);
        if (bus.cmp_valid && tc < 0) begin
          tc = c; ce = bus.cmp_err; ci = bus.cmp_id;
        end
      end
      chk($sformatf("bad%0d_pulses", j), pulses, 0);
      chk($sformatf("bad%0d_writes", j), wrs, 0);
      chk($sformatf("bad%0d_cmp_window", j), int'(tc >= 2 && tc <= 4), 1);
      chk($sformatf("bad%0d_err", j), int'(ce), 1);
      chk($sformatf("bad%0d_id", j), int'(ci), (j == 0) ? 2 : 1);
      chk($sformatf("bad%0d_busy", j), int'(bus.busy), 0);
    end

    // Stalled blocker (id 3) in RUN while five requests arrive; queue fills after four
    tick();
    drive(1, 0, 2, 0, 3, 0, 0, 0);
    found = 0;
    for (int k = 0; k < 10; k++) begin
      if (found == 0) begin
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        if (bus.sm_start) found = 1;
      end
    end
    chk("blk_start_seen", found, 1);
    acc = 0; tcmp = -1; rdy4 = 1'b1; cerr_b = 1'b0; cid_b = 2'b00; rst_after = 1'b0;
    for (int t = 0; t <= TO + 1; t++) begin
      tick();
      if (t < 5) drive(1, 0, 2, 0, t, 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      if (t < 5 && bus.req_ready) acc++;
      if (t == 4) rdy4 = bus.req_ready;
      if (bus.cmp_valid && tcmp < 0) begin
        tcmp = t; cerr_b = bus.cmp_err; cid_b = bus.cmp_id;
      end
      if (t == TO + 1) rst_after = bus.sm_rst;
    end
    chk("qfull_accepts", acc, 4);
    chk("qfull_ready_low", int'(rdy4), 0);
    chk("tmo_cycle", tcmp, TO);
    chk("tmo_err", int'(cerr_b), 1);
    chk("tmo_id", int'(cid_b), 3);
    chk("tmo_next_rst", int'(rst_after), 1);
    errall = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (ids.size() < 4) begin
        tick();
        #1;
        if (bus.cmp_valid) begin
          ids.push_back(int'(bus.cmp_id));
          errall = errall & bus.cmp_err;
        end
      end
    end
    chk("qfull_cmp_count", ids.size(), 4);
    foreach (ids[i]) chk($sformatf("qfull_order%0d", i), ids[i], i);
    chk("qfull_all_err", int'(errall), 1);
    tick();
    #1;
    chk("qfull_idle_busy", int'(bus.busy), 0);

    // Reset in the middle of a 4-beat job with a second job queued behind it
    tick();
    drive(1, 0, 4, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 4, 0, 2, 0, 0, 0);
    found = 0;
    for (int k = 0; k < 10; k++) begin
      if (found == 0) begin
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        if (bus.sm_start) found = 1;
      end
    end
    chk("rst_start_seen", found, 1);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h1, 32'h0);
    #1;
    chk("rst_beat1_addr", int'(bus.wr_en) * 1000 + int'(bus.wr_addr), 1000);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h2, 32'h0);
    #1;
    chk("rst_beat2_addr", int'(bus.wr_en) * 1000 + int'(bus.wr_addr), 1001);
    z = '0; z.rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 1, 32'h3, 32'h0);
      #1;
      chk_out($sformatf("rst_mid%0d", k), sample(), z);
    end
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cvs = 0; rsts = 0; bzs = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      #1;
      cvs  += int'(bus.cmp_valid);
      rsts += int'(bus.sm_rst);
      bzs  += int'(bus.busy);
    end
    chk("rst_no_cmp", cvs, 0);
    chk("rst_no_new_job", rsts, 0);
    chk("rst_busy_low", bzs, 0);
    chk("rst_queue_empty_ready", int'(bus.req_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
